// File: rtl/ccff_chain_loader_if.sv
// Bitstream word stream into the ccff chain loader.
// Source drives data/valid/last; the loader returns ready.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_last;
  logic              cfg_ready;

  modport master (
    output cfg_data,
    output cfg_valid,
    output cfg_last,
    input  cfg_ready
  );

  modport slave (
    input  cfg_data,
    input  cfg_valid,
    input  cfg_last,
    output cfg_ready
  );
endinterface

// File: rtl/ccff_chain_loader.sv
// Serializes bitstream words onto the ccff chain head, gating prog_clk.
// Optional tail readback is built only with CCFF_READBACK_EN defined.
module ccff_chain_loader #(
  parameter  int CHAIN_LEN = 20,
  parameter  int WORD_W    = 8,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  ccff_chain_loader_if.slave cfg,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] word;
  logic              last_flag;
  logic [IDX_W-1:0]  bit_idx;
  logic [IDX_W-1:0]  idx_nx;
  logic [CNT_W-1:0]  bit_cnt;
  logic              chain_full;
  logic              word_end;

  // chain_full / word_end describe the bit being shifted this cycle
  always_comb begin
    chain_full = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
    word_end   = chain_full ||
                 (bit_idx == IDX_W'(WORD_W - 1));
    idx_nx     = bit_idx + IDX_W'(1);
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state         <= IDLE;
      word          <= '0;
      last_flag     <= 1'b0;
      bit_idx       <= '0;
      bit_cnt       <= '0;
      cfg.cfg_ready <= 1'b0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state         <= FETCH;
            busy          <= 1'b1;
            cfg.cfg_ready <= 1'b1;
            err           <= 1'b0;
            bit_cnt       <= '0;
          end
        end
        FETCH: begin
          if (cfg.cfg_valid) begin
            state         <= SHIFT;
            word          <= cfg.cfg_data;
            last_flag     <= cfg.cfg_last;
            bit_idx       <= '0;
            cfg.cfg_ready <= 1'b0;
            ccff_shift_en <= 1'b1;
            ccff_head     <= cfg.cfg_data[0];
          end
        end
        SHIFT: begin
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (word_end) begin
            ccff_shift_en <= 1'b0;
            ccff_head     <= 1'b0;
            if (chain_full || last_flag) begin
              state <= DONE;
              done  <= 1'b1;
              // framing is clean only when last and full coincide
              err   <= err | (chain_full ^ last_flag);
            end else begin
              state         <= FETCH;
              cfg.cfg_ready <= 1'b1;
            end
          end else begin
            bit_idx   <= idx_nx;
            ccff_head <= word[idx_nx];
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CCFF_READBACK_EN
  logic [WORD_W-1:0] rb_acc;
  logic [WORD_W-1:0] rb_cur;

  always_comb begin
    rb_cur          = rb_acc;
    rb_cur[bit_idx] = ccff_tail;
  end

  // tail is sampled before the edge that shifts it out
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      rb_acc   <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (state == SHIFT) begin
        if (word_end) begin
          rb_data  <= rb_cur;
          rb_valid <= 1'b1;
          rb_acc   <= '0;
        end else begin
          rb_acc <= rb_cur;
        end
      end
    end
  end
`else
  logic unused_tail;

  assign unused_tail = ccff_tail;
  assign rb_data     = '0;
  assign rb_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader with a chain model on head/tail.
// Readback checks are active when CCFF_READBACK_EN is defined.
module tb_ccff_chain_loader;
  localparam int LEN = 20;
  localparam int W   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start;
  logic         ccff_head;
  logic         shift_en;
  logic         tail;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] rb_data;
  logic         rb_valid;

  ccff_chain_loader_if #(.WORD_W(W)) cfg_if();

  ccff_chain_loader #(
    .CHAIN_LEN(LEN),
    .WORD_W(W)
  ) dut (
    .prog_clk(clk),
    .pReset(rst_n),
    .start(start),
    .cfg(cfg_if),
    .ccff_head(ccff_head),
    .ccff_shift_en(shift_en),
    .ccff_tail(tail),
    .busy(busy),
    .done(done),
    .err(err),
    .rb_data(rb_data),
    .rb_valid(rb_valid)
  );

  logic [LEN-1:0] chain;
  logic [LEN-1:0] preload_val;
  logic           preload_req;

  // physical chain: bit 0 at head, bit LEN-1 at tail
  always @(posedge clk) begin
    if (preload_req) chain <= preload_val;
    else if (shift_en) chain <= {chain[LEN-2:0], ccff_head};
  end
  assign tail = chain[LEN-1];

  typedef struct {
    bit err;
    int n;
  } done_t;

  int           checks = 0;
  int           failures = 0;
  int           seen_shifts = 0;
  int           load_shifts = 0;
  bit           exp_bits[$];
  done_t        exp_done[$];
  logic [W-1:0] exp_rb[$];
  bit           ref_q[$];
  logic [W-1:0] wbuf[4];
  bit           prev_err;
  bit           pchk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=none required=event t=%0t",
             name, $time);
  endtask

  initial begin : monitor
    bit    b;
    done_t d;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        load_shifts = 0;
      end else begin
        if (shift_en) begin
          seen_shifts++;
          load_shifts++;
          if (exp_bits.size() == 0) miss("spurious_shift");
          else begin
            b = exp_bits.pop_front();
            chk("head_bit", 32'(ccff_head), 32'(b));
          end
        end
        if (done) begin
          if (exp_done.size() == 0) miss("spurious_done");
          else begin
            d = exp_done.pop_front();
            chk("done_err", 32'(err), 32'(d.err));
            chk("shift_count", 32'(load_shifts), 32'(d.n));
          end
`ifndef CCFF_READBACK_EN
          chk("rb_off", {23'd0, rb_valid, rb_data}, 32'd0);
`endif
          load_shifts = 0;
        end
`ifdef CCFF_READBACK_EN
        if (rb_valid) begin
          if (exp_rb.size() == 0) miss("spurious_rb");
          else chk("rb_data", 32'(rb_data), 32'(exp_rb.pop_front()));
        end
`endif
      end
    end
  end

  function automatic logic [31:0] outs();
    return {22'd0, cfg_if.cfg_ready, ccff_head, shift_en,
            busy, done, err, rb_valid, rb_data} >> 0;
  endfunction

  // expected stream: words LSB first, cut at LEN bits or at cfg_last
  task automatic model(input int nw, input int last_idx,
                       output int n_used, output bit e);
    int           n;
    int           take;
    bit           o;
    logic [W-1:0] acc;
    done_t        d;
    n = 0;
    e = 1'b1;
    n_used = 0;
    for (int k = 0; k < nw; k++) begin
      take = (LEN - n < W) ? LEN - n : W;
      acc = '0;
      for (int b = 0; b < take; b++) begin
        exp_bits.push_back(wbuf[k][b]);
        o = ref_q.pop_front();
        ref_q.push_back(wbuf[k][b]);
        acc[b] = o;
      end
`ifdef CCFF_READBACK_EN
      exp_rb.push_back(acc);
`endif
      n += take;
      n_used = k + 1;
      if (n == LEN) begin
        e = (k != last_idx);
        break;
      end
      if (k == last_idx) break;
    end
    d.err = e;
    d.n = n;
    exp_done.push_back(d);
  endtask

  task automatic preload(input logic [LEN-1:0] v);
    @(posedge clk); #1;
    preload_val = v;
    preload_req = 1'b1;
    @(posedge clk); #1;
    preload_req = 1'b0;
    ref_q.delete();
    for (int i = LEN - 1; i >= 0; i--) ref_q.push_back(v[i]);
  endtask

  task automatic flush();
    exp_bits.delete();
    exp_done.delete();
    exp_rb.delete();
  endtask

  task automatic recover();
    rst_n = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    start = 1'b0;
    pchk = 1'b0;
    flush();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    prev_err = 1'b0;
  endtask

  task automatic neg();
    @(negedge clk); #1;
    if (pchk) begin
      pchk = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("err_cleared", 32'(err), 32'd0);
    end
  endtask

  task automatic put_word(input int k, input int last_idx);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = wbuf[k];
    cfg_if.cfg_last  = (k == last_idx);
  endtask

  task automatic run_load(input int nw, input int last_idx,
                          input int stall_idx, input int stall_len,
                          input bit rand_gaps, input bit start_mid,
                          input bit abort10);
    int n_used;
    bit e;
    int base;
    int gap;
    bit hs;
    model(nw, last_idx, n_used, e);
    chk("err_sticky", 32'(err), 32'(prev_err));
    base = seen_shifts;
    @(posedge clk); #1;
    start = 1'b1;
    @(negedge clk); #1;
    chk("busy_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    pchk = 1'b1;
    for (int k = 0; k < n_used; k++) begin
      gap = (k == stall_idx) ? stall_len :
            (rand_gaps ? int'($urandom_range(0, 3)) : 0);
      if (gap == 0) begin
        put_word(k, last_idx);
        neg();
      end else begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data = W'($urandom);
        hs = 1'b0;
        for (int t = 0; t < 64; t++) begin
          neg();
          if (cfg_if.cfg_ready) begin
            hs = 1'b1;
            break;
          end
        end
        if (!hs) begin
          miss("fetch_ready_timeout");
          recover();
          return;
        end
        repeat (gap) begin
          @(posedge clk); #1;
          neg();
          chk("stall_no_shift", 32'(shift_en), 32'd0);
        end
        put_word(k, last_idx);
      end
      hs = 1'b0;
      for (int t = 0; t < 64; t++) begin
        if (cfg_if.cfg_ready) begin
          @(posedge clk); #1;
          cfg_if.cfg_valid = 1'b0;
          cfg_if.cfg_last = 1'b0;
          cfg_if.cfg_data = W'($urandom);
          hs = 1'b1;
          break;
        end
        neg();
      end
      if (!hs) begin
        miss("handshake_timeout");
        recover();
        return;
      end
      if (start_mid && k == 0) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (abort10 && k == 1) begin
        for (int t = 0; t < 40; t++) begin
          neg();
          if (seen_shifts - base >= 10) break;
        end
        chk("abort_point", 32'(seen_shifts - base), 32'd10);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs_zero", outs(), 32'd0);
        flush();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        prev_err = 1'b0;
        return;
      end
    end
    hs = 1'b0;
    for (int t = 0; t < 200; t++) begin
      neg();
      if (done) begin
        hs = 1'b1;
        break;
      end
    end
    if (!hs) begin
      miss("done_timeout");
      recover();
      return;
    end
    prev_err = e;
    neg();
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_single", 32'(done), 32'd0);
    chk("ready_idle", 32'(cfg_if.cfg_ready), 32'd0);
    chk("bits_left", 32'(exp_bits.size()), 32'd0);
    chk("rb_left", 32'(exp_rb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic set_std();
    wbuf[0] = 8'hA5;
    wbuf[1] = 8'h3C;
    wbuf[2] = 8'h0F;
    wbuf[3] = 8'h00;
  endtask

  initial begin
    int li;
    rst_n = 1'b1;
    start = 1'b0;
    preload_req = 1'b0;
    preload_val = '0;
    pchk = 1'b0;
    prev_err = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_last = 1'b0;
    cfg_if.cfg_data = '0;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = 1'($urandom);
      cfg_if.cfg_valid = 1'($urandom);
      cfg_if.cfg_last = 1'($urandom);
      cfg_if.cfg_data = W'($urandom);
      @(negedge clk); #1;
      chk("reset_outputs", outs(), 32'd0);
    end
    start = 1'b0;
    preload(20'hFFFFF);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cfg_if.cfg_valid = 1'($urandom);
      cfg_if.cfg_data = W'($urandom);
      @(negedge clk); #1;
      chk("idle_outputs", outs(), 32'd0);
    end
    cfg_if.cfg_valid = 1'b0;
    @(posedge clk); #1;

    set_std();
    run_load(3, 2, -1, 0, 1'b0, 1'b0, 1'b0);
    run_load(3, 2, -1, 0, 1'b0, 1'b0, 1'b0);
    run_load(3, 2, 1, 5, 1'b0, 1'b1, 1'b0);
    run_load(3, 1, -1, 0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) wbuf[k] = W'($urandom);
    run_load(3, -1, -1, 0, 1'b1, 1'b0, 1'b0);
    set_std();
    run_load(3, 2, -1, 0, 1'b0, 1'b0, 1'b1);
    preload(LEN'($urandom));
    run_load(3, 2, -1, 0, 1'b0, 1'b1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      if (r % 3 == 0) preload(LEN'($urandom));
      for (int k = 0; k < 4; k++) wbuf[k] = W'($urandom);
      li = int'($urandom_range(0, 4)) - 1;
      run_load(4, li, int'($urandom_range(0, 3)),
               int'($urandom_range(1, 6)), 1'b1,
               1'($urandom), 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
